// File: rtl/ex_arith_unit.sv
// ex_arith_unit: execute-stage arithmetic for the five-stage MIPS pipeline.
// It holds the 32-bit ALU, the PC+4 and branch-target adders, and the
// branch-delay detector. The detector has a combinational flag and a
// registered copy for the hazard unit.
module ex_arith_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic        alu_overflow,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [31:0] if_id_pc,
  input  logic [31:0] imm_ext,
  output logic [31:0] branch_target,
  input  logic [1:0]  id_ex_branch,
  input  logic        id_ex_pc_src,
  output logic        delay,
  output logic        delay_q
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADDU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SUBU  = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1101;
  localparam logic [3:0] OP_PASSA = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_shamt;
  logic [31:0] w_sra;
  logic        w_slt;
  logic        w_sltu;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic        w_delay;
  logic        w_unused_imm_hi;
  logic        r_delay_q;

  // One shared adder and one shared subtractor feed the arithmetic ops.
  assign w_sum   = alu_a + alu_b;
  assign w_diff  = alu_a - alu_b;
  assign w_shamt = alu_a[4:0];
  assign w_sra   = $signed(alu_b) >>> w_shamt;

  // Signed compare: when the signs differ, a is less exactly when a is negative.
  // Otherwise the difference cannot overflow and its sign decides.
  assign w_slt  = (alu_a[31] != alu_b[31]) ? alu_a[31] : w_diff[31];
  assign w_sltu = (alu_a < alu_b);

  // Overflow happens when the result sign cannot come from the operand signs.
  assign w_add_ovf = (alu_a[31] == alu_b[31]) && (w_sum[31]  != alu_a[31]);
  assign w_sub_ovf = (alu_a[31] != alu_b[31]) && (w_diff[31] != alu_a[31]);

  // ALU result and overflow mux; overflow is reported only for ADD and SUB.
  always_comb begin
    alu_result   = 32'h0000_0000;
    alu_overflow = 1'b0;
    case (alu_control)
      OP_AND:   alu_result = alu_a & alu_b;
      OP_OR:    alu_result = alu_a | alu_b;
      OP_ADD: begin
        alu_result   = w_sum;
        alu_overflow = w_add_ovf;
      end
      OP_ADDU:  alu_result = w_sum;
      OP_XOR:   alu_result = alu_a ^ alu_b;
      OP_NOR:   alu_result = ~(alu_a | alu_b);
      OP_SUB: begin
        alu_result   = w_diff;
        alu_overflow = w_sub_ovf;
      end
      OP_SLT:   alu_result = {31'b0, w_slt};
      OP_SUBU:  alu_result = w_diff;
      OP_SLTU:  alu_result = {31'b0, w_sltu};
      OP_SLL:   alu_result = alu_b << w_shamt;
      OP_SRL:   alu_result = alu_b >> w_shamt;
      OP_SRA:   alu_result = w_sra;
      OP_LUI:   alu_result = {alu_b[15:0], 16'h0000};
      OP_PASSA: alu_result = alu_a;
      OP_PASSB: alu_result = alu_b;
      default:  alu_result = 32'h0000_0000;
    endcase
  end

  assign alu_zero = (alu_result == 32'h0000_0000);

  // The PC adders wrap modulo 2^32. Word-aligning the immediate drops imm_ext[31:30].
  assign pc_plus4        = pc + 32'd4;
  assign branch_target   = if_id_pc + {imm_ext[29:0], 2'b00};
  assign w_unused_imm_hi = ^imm_ext[31:30];

  // Any non-zero branch type (including the reserved 11) counts as a branch.
  assign w_delay = (id_ex_branch != 2'b00) && id_ex_pc_src;
  assign delay   = w_delay;

  // Registered delay flag; reset clears it at once and drops any in-flight branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_q <= 1'b0;
    end else begin
      r_delay_q <= w_delay;
    end
  end

  assign delay_q = r_delay_q;

endmodule

// File: tb/tb_ex_arith_unit.sv
// tb_ex_arith_unit: directed corner cases and randomized vectors for
// ex_arith_unit. The results are checked against a behavioural model that
// uses wide signed arithmetic.
module tb_ex_arith_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc;
  logic [31:0] imm_ext;
  logic [31:0] branch_target;
  logic [1:0]  id_ex_branch;
  logic        id_ex_pc_src;
  logic        delay;
  logic        delay_q;

  int n_vec;
  int n_err;

  ex_arith_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .if_id_pc      (if_id_pc),
    .imm_ext       (imm_ext),
    .branch_target (branch_target),
    .id_ex_branch  (id_ex_branch),
    .id_ex_pc_src  (id_ex_pc_src),
    .delay         (delay),
    .delay_q       (delay_q)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural ALU model that works on the signed or unsigned value of each operand.
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf);
    longint sa, sb, wide;
    int     b_int;
    int     sh;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    b_int = b;
    sh    = int'(a % 32);
    ovf   = 1'b0;
    res   = 32'h0;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2: begin
        wide = sa + sb;
        res  = wide[31:0];
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd3:  res = a + b;
      4'd4:  res = a ^ b;
      4'd5:  res = ~(a | b);
      4'd6: begin
        wide = sa - sb;
        res  = wide[31:0];
        ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  res = a - b;
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      4'd10: res = b * (32'd1 << sh);
      4'd11: res = b / (32'd1 << sh);
      4'd12: res = 32'(b_int >>> sh);
      4'd13: res = (b % 32'h0001_0000) * 32'h0001_0000;
      4'd14: res = a;
      default: res = b;
    endcase
  endtask

  // Drive an ALU op, let it settle, and compare all three ALU outputs.
  task automatic apply_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    logic        exp_ovf;
    alu_control = op;
    alu_a       = a;
    alu_b       = b;
    #1;
    ref_alu(op, a, b, exp_res, exp_ovf);
    check($sformatf("alu_result op%0d", op), alu_result, exp_res);
    check($sformatf("alu_zero op%0d", op), {31'b0, alu_zero}, {31'b0, exp_res == 32'h0});
    check($sformatf("alu_overflow op%0d", op), {31'b0, alu_overflow}, {31'b0, exp_ovf});
  endtask

  // Drive the PC adders and compare both sums.
  task automatic apply_pc(input logic [31:0] p, input logic [31:0] ifpc, input logic [31:0] imm);
    pc       = p;
    if_id_pc = ifpc;
    imm_ext  = imm;
    #1;
    check("pc_plus4", pc_plus4, p + 32'd4);
    check("branch_target", branch_target, ifpc + imm * 32'd4);
  endtask

  // Mostly boundary values, with some fully random words.
  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic exp_d;
  logic exp_dq;

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    alu_a        = 32'h0;
    alu_b        = 32'h0;
    alu_control  = 4'h0;
    pc           = 32'h0;
    if_id_pc     = 32'h0;
    imm_ext      = 32'h0;
    id_ex_branch = 2'b01;
    id_ex_pc_src = 1'b1;

    // Reset state: delay_q is held low through edges, and delay still follows its inputs.
    repeat (2) @(negedge clk);
    #1;
    check("reset delay_q", {31'b0, delay_q}, 32'h0);
    check("reset delay comb", {31'b0, delay}, 32'h1);
    id_ex_branch = 2'b00;
    id_ex_pc_src = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed ALU corners.
    apply_alu(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add ovf result", alu_result, 32'h8000_0000);
    apply_alu(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001);
    apply_alu(4'b0110, 32'd5, 32'd5);
    check("sub zero", {31'b0, alu_zero}, 32'h1);
    apply_alu(4'b0110, 32'h8000_0000, 32'h0000_0001);
    apply_alu(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt neg", alu_result, 32'h1);
    apply_alu(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu big", alu_result, 32'h0);
    apply_alu(4'b1100, 32'd4, 32'h8000_0000);
    check("sra", alu_result, 32'hF800_0000);
    apply_alu(4'b1011, 32'd4, 32'h8000_0000);
    check("srl", alu_result, 32'h0800_0000);
    apply_alu(4'b1010, 32'h0000_0021, 32'h0000_0001);
    check("sll shamt masked", alu_result, 32'h2);
    apply_alu(4'b1101, 32'h0, 32'h0000_1234);
    check("lui", alu_result, 32'h1234_0000);
    apply_alu(4'b0101, 32'h0, 32'h0);
    check("nor zero", alu_result, 32'hFFFF_FFFF);
    apply_alu(4'b1111, 32'h1111_1111, 32'hCAFE_BABE);
    check("passb", alu_result, 32'hCAFE_BABE);

    // Directed PC adder corners.
    apply_pc(32'hFFFF_FFFC, 32'h0000_0100, 32'hFFFF_FFFF);
    check("pc wrap", pc_plus4, 32'h0);
    check("branch back", branch_target, 32'h0000_00FC);
    apply_pc(32'h0040_0000, 32'h0040_0004, 32'h0000_7FFF);

    // Randomized ALU and adder vectors.
    for (int i = 0; i < 400; i++) begin
      apply_alu(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end
    for (int i = 0; i < 50; i++) begin
      apply_pc(pick_operand(), pick_operand(), pick_operand());
    end

    // Delay flag: directed cases, then a random sequence. The inputs change only after a falling edge.
    @(negedge clk);
    id_ex_branch = 2'b01;
    id_ex_pc_src = 1'b1;
    #1;
    check("delay beq taken", {31'b0, delay}, 32'h1);
    @(negedge clk);
    check("delay_q after edge", {31'b0, delay_q}, 32'h1);
    id_ex_branch = 2'b00;
    id_ex_pc_src = 1'b1;
    #1;
    check("delay no branch", {31'b0, delay}, 32'h0);
    id_ex_branch = 2'b11;
    #1;
    check("delay reserved", {31'b0, delay}, 32'h1);

    exp_dq = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("delay_q seq", {31'b0, delay_q}, {31'b0, exp_dq});
      id_ex_branch = 2'($urandom_range(0, 3));
      id_ex_pc_src = 1'($urandom_range(0, 1));
      #1;
      exp_d = (id_ex_branch != 2'b00) && id_ex_pc_src;
      check("delay seq", {31'b0, delay}, {31'b0, exp_d});
      exp_dq = exp_d;
    end

    // Asserting reset mid-cycle clears delay_q at once and holds it low across edges.
    @(negedge clk);
    id_ex_branch = 2'b10;
    id_ex_pc_src = 1'b1;
    @(negedge clk);
    check("delay_q pre reset", {31'b0, delay_q}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("delay_q async clear", {31'b0, delay_q}, 32'h0);
    check("delay during reset", {31'b0, delay}, 32'h1);
    repeat (2) begin
      @(negedge clk);
      check("delay_q held in reset", {31'b0, delay_q}, 32'h0);
    end
    #1;
    rst_n = 1'b1;
    #1;
    check("delay_q after release", {31'b0, delay_q}, 32'h0);
    @(negedge clk);
    check("delay_q first edge", {31'b0, delay_q}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
